// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Registered ALU with valid/ready handshake on both sides, an
//             internally held {n, v, z} flag register and an iterative
//             shift-add unsigned multiplier (one multiplier bit per cycle).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      op/operands presented this cycle
//    in_ready   out  1      an operation is accepted this cycle
//    op         in   4      0 ADD,1 SUB,2 AND,3 OR,4 SLL,5 SRL,6 SRA,7 RL,8 MUL
//    a, b       in   DSIZE  operands (two's complement)
//    imm        in   SHW    shift / rotate amount
//    out_valid  out  1      out and flag hold a result
//    out_ready  in   1      consumer takes the result this cycle
//    out        out  DSIZE  registered result
//    flag       out  3      registered {n, v, z}
// ============================================================================
module alu_pipe #(
  parameter int DSIZE = 16,
  parameter int SHW   = $clog2(DSIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [SHW-1:0]   imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [2:0]       flag
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_RL  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Counter must be able to hold DSIZE itself.
  localparam int CW = $clog2(DSIZE + 1);
  localparam int M  = DSIZE - 1;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DSIZE-1:0]       out_q, out_d;
  logic [2:0]             flag_q, flag_d;
  logic                   out_valid_q, out_valid_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*DSIZE-1:0]     acc_q, acc_d;
  logic [2*DSIZE-1:0]     mcand_q, mcand_d;
  logic [DSIZE-1:0]       mplier_q, mplier_d;

  // --------------------------------------------------------------------------
  // Single-cycle datapath
  // --------------------------------------------------------------------------
  logic [DSIZE-1:0]        sum_w, diff_w;
  logic                    ovf_add_w, ovf_sub_w;
  logic signed [DSIZE-1:0] sra_w;
  logic [2*DSIZE-1:0]      rot_w;
  logic [DSIZE-1:0]        alu_res;
  logic [2:0]              alu_flag;

  assign sum_w     = a + b;
  assign diff_w    = a - b;
  assign ovf_add_w = (a[M] == b[M]) && (sum_w[M]  != a[M]);
  assign ovf_sub_w = (a[M] != b[M]) && (diff_w[M] != a[M]);
  assign sra_w     = $signed(a) >>> imm;
  // Rotate as the upper half of a doubled word shifted left; imm = 0 gives a.
  assign rot_w     = {a, a} << imm;

  always_comb begin
    alu_res  = '0;
    alu_flag = flag_q;
    case (op)
      OP_ADD: begin
        alu_res  = sum_w;
        alu_flag = {sum_w[M] && !ovf_add_w, ovf_add_w, sum_w == '0};
      end
      OP_SUB: begin
        alu_res  = diff_w;
        alu_flag = {diff_w[M] && !ovf_sub_w, ovf_sub_w, diff_w == '0};
      end
      OP_AND: begin
        alu_res  = a & b;
        alu_flag = {2'b00, (a & b) == '0};
      end
      OP_OR: begin
        alu_res  = a | b;
        alu_flag = {2'b00, (a | b) == '0};
      end
      OP_SLL:  alu_res = a << imm;
      OP_SRL:  alu_res = a >> imm;
      OP_SRA:  alu_res = sra_w;
      OP_RL:   alu_res = rot_w[2*DSIZE-1:DSIZE];
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake and control
  // --------------------------------------------------------------------------
  logic accept_w;
  logic pop_w;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_w = in_valid && in_ready;
  assign pop_w    = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    flag_d      = flag_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;

    if (pop_w) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept_w) begin
          if (op == OP_MUL) begin
            state_d  = MUL_BUSY;
            cnt_d    = CW'(DSIZE);
            acc_d    = '0;
            mcand_d  = {{DSIZE{1'b0}}, a};
            mplier_d = b;
          end else begin
            out_d       = alu_res;
            flag_d      = alu_flag;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        if (cnt_q != '0) begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
        end else if (!out_valid_q || out_ready) begin
          // Output register is normally empty here (it was popped on the MUL
          // accept edge); the guard keeps a stalled result from being lost.
          out_d       = acc_q[DSIZE-1:0];
          flag_d      = {1'b0, acc_q[2*DSIZE-1:DSIZE] != '0, acc_q[DSIZE-1:0] == '0};
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      flag_q      <= 3'b000;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
    end
  end

  assign out       = out_q;
  assign flag      = flag_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Directed self-checking bench for alu_pipe (DSIZE = 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  localparam int DSIZE = 16;
  localparam int SHW   = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [DSIZE-1:0] a;
  logic [DSIZE-1:0] b;
  logic [SHW-1:0]   imm;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out;
  logic [2:0]       flag;

  int n_checks;
  int n_fails;

  alu_pipe #(.DSIZE(DSIZE), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag      (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb,
                       input logic [3:0] vi);
    in_valid = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
    imm      = vi;
  endtask

  // Single-cycle op with out_ready held high: result visible after one edge.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [15:0] va,
                       input logic [15:0] vb, input logic [3:0] vi,
                       input logic [15:0] exp_out, input logic [2:0] exp_flag);
    drive(o, va, vb, vi);
    tick();
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".out"},   {16'd0, out},       {16'd0, exp_out});
    check({tag, ".flag"},  {29'd0, flag},      {29'd0, exp_flag});
  endtask

  int bad;

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    a         = '0;
    b         = '0;
    imm       = '0;

    repeat (3) @(posedge clk);
    #3;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out",       {16'd0, out},       32'd0);
    check("rst.flag",      {29'd0, flag},      32'd0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready",  {31'd0, in_ready},  32'd1);

    // Align to just after an edge before streaming.
    tick();

    // Continuous stream of single-cycle ops, one per cycle.
    do_op("add_ovf",  4'd0, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 3'b010);
    do_op("sub_zero", 4'd1, 16'h0005, 16'h0005, 4'd0,  16'h0000, 3'b001);
    do_op("sll15",    4'd4, 16'h0001, 16'h0000, 4'd15, 16'h8000, 3'b001);
    do_op("rl1",      4'd7, 16'h8001, 16'h0000, 4'd1,  16'h0003, 3'b001);
    do_op("sra15",    4'd6, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 3'b001);
    do_op("rl0",      4'd7, 16'h1234, 16'h0000, 4'd0,  16'h1234, 3'b001);
    do_op("or",       4'd3, 16'h00F0, 16'h0F00, 4'd0,  16'h0FF0, 3'b000);
    do_op("and_zero", 4'd2, 16'hF0F0, 16'h0F0F, 4'd0,  16'h0000, 3'b001);
    do_op("sub_ovf",  4'd1, 16'h8000, 16'h0001, 4'd0,  16'h7FFF, 3'b010);
    do_op("add_neg",  4'd0, 16'hFFFF, 16'hFFFF, 4'd0,  16'hFFFE, 3'b100);
    do_op("srl4",     4'd5, 16'h8000, 16'h0000, 4'd4,  16'h0800, 3'b100);
    do_op("undef9",   4'd9, 16'h1234, 16'h5678, 4'd3,  16'h0000, 3'b100);

    // MUL 0x100 * 0x100: low half zero, high half nonzero.
    drive(4'd8, 16'h0100, 16'h0100, 4'd0);
    tick();
    in_valid = 1'b0;
    check("mul.accept_ir", {31'd0, in_ready}, 32'd0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    check("mul.busy_cycles", bad, 0);
    tick();
    check("mul.valid17", {31'd0, out_valid}, 32'd1);
    check("mul.out",       {16'd0, out},       32'd0);
    check("mul.flag",      {29'd0, flag},      32'b011);

    // MUL 3 * 7.
    drive(4'd8, 16'd3, 16'd7, 4'd0);
    tick();
    in_valid = 1'b0;
    repeat (16) tick();
    check("mul37.early", {31'd0, out_valid}, 32'd0);
    tick();
    check("mul37.valid", {31'd0, out_valid}, 32'd1);
    check("mul37.out",   {16'd0, out},       32'd21);
    check("mul37.flag",  {29'd0, flag},      32'd0);
    tick();
    check("mul37.pop",   {31'd0, out_valid}, 32'd0);

    // Back-pressure: result stalls, second op waits, then pop+accept together.
    out_ready = 1'b0;
    drive(4'd0, 16'd1, 16'd2, 4'd0);
    tick();
    check("bp.first_out", {16'd0, out}, 32'd3);
    drive(4'd0, 16'd10, 16'd20, 4'd0);
    #1;
    check("bp.in_ready_lo", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    check("bp.out_hold",   {16'd0, out},       32'd3);
    check("bp.valid_hold", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_hi", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp.second_out",   {16'd0, out},       32'd30);
    check("bp.second_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("bp.drain", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a MUL.
    do_op("pre_rst", 4'd0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 3'b010);
    drive(4'd8, 16'd3, 16'd7, 4'd0);
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst.out",       {16'd0, out},       32'd0);
    check("mrst.flag",      {29'd0, flag},      32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("mrst.in_ready", {31'd0, in_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    check("mrst.no_stale", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU. Adds a valid/ready handshake, a registered result and an internally held flag register, which replaces the external lastFlag feedback.
- Adds an iterative multi-cycle unsigned MUL (shift-add, one bit per cycle).
- Sits between the ID/EX operand latch and writeback. The processor core stalls on in_ready / out_valid.

Parameters:
- DSIZE, 16, datapath width in bits; must be a power of two, at least 4.
- SHW, $clog2(DSIZE), width of the shift/rotate amount imm.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op presented this cycle.
- in_ready  output  1  block accepts an operation this cycle.
- op  input  4  operation code (see Behaviour).
- a  input  DSIZE  operand A, two's complement.
- b  input  DSIZE  operand B, two's complement.
- imm  input  SHW  shift/rotate amount.
- out_valid  output  1  result and flag valid.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  DSIZE  registered result.
- flag  output  3  registered {n, v, z}.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, out = 0, flag = 3'b000, out_valid = 0, MUL counter and accumulator = 0. An in-flight MUL is abandoned; no result is produced for it.
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, SLL 4, SRL 5, SRA 6, RL 7, MUL 8. Codes 9-15 give out = 0 and leave flag unchanged.
- Accept: a transfer occurs when in_valid && in_ready. in_ready = (state == IDLE) && (!out_valid || out_ready). A back-to-back accept in the same cycle as an out_ready pop is legal.
- Single-cycle ops (0-7): the result is registered on the accept edge, and out_valid is 1 from the next cycle. With a continuous stream, throughput is 1 op per cycle.
- MUL:
  - On accept: state goes to MUL_BUSY, the counter loads DSIZE, a and b are latched, in_ready = 0.
  - Each cycle: if the multiplier LSB is 1, add the shifted multiplicand into a 2*DSIZE-bit accumulator; then shift.
  - When the counter reaches 0: out = acc[DSIZE-1:0], out_valid = 1, state = IDLE.
  - Latency from the accept edge to out_valid is DSIZE+1 cycles.
- Output hold: out and flag stay stable while out_valid && !out_ready. out_valid drops the cycle after a pop unless a new result is registered on the same edge.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^DSIZE.
  - SLL, SRL: logical shifts.
  - SRA: arithmetic shift, replicating a[DSIZE-1].
  - RL: rotate left by imm; imm = 0 gives out = a.
- Flags, updated together with out at the registering edge:
  - ADD/SUB: z = (res == 0). v = signed overflow: ADD when a, b have the same sign and res sign differs from a; SUB when a, b differ in sign and res sign differs from a. n = res[DSIZE-1] && !v.
  - AND/OR: z = (res == 0), v = 0, n = 0.
  - MUL: z = (low result == 0), v = (acc[2*DSIZE-1:DSIZE] != 0), n = 0.
  - Shifts, rotates and undefined ops: flag holds its previous value.
- No operation is dropped. in_ready stays low while a result sits unconsumed and a new result would be needed.

Test Plan:
- Reset then ADD a=0x7FFF, b=0x0001 -> next cycle out_valid=1, out=0x8000, flag={n=0, v=1, z=0}.
- SUB a=5, b=5, then SLL a=0x0001, imm=15 -> first result 0x0000 with flag=3'b001; SLL gives out=0x8000 with flag still 3'b001.
- RL a=0x8001, imm=1 -> 0x0003; SRA a=0x8000, imm=15 -> 0xFFFF; RL imm=0 -> out=a.
- MUL a=0x0100, b=0x0100, DSIZE=16 -> in_ready=0 for 16 cycles, out_valid at accept+17, out=0x0000, flag={0, 1, 1}. MUL 3*7 -> out=21, flag=000.
- Hold out_ready=0 with in_valid=1 and two ADDs queued -> in_ready=0 and out stable; raising out_ready pops the first result and accepts the second on the same edge.
- Assert rst_n=0 mid-MUL (cycle 8) -> out_valid=0, out=0, flag=0 immediately. After release, in_ready=1 and no stale result appears.
